// File: rtl/vga_rx.sv
// ---------------------------------------------------------------------------
// vga_rx -- VGA timing receiver / pixel recoverer
//
// Samples an incoming VGA stream (hsync, vsync, 3-bit red/green/blue) on the
// pixel clock and recovers the horizontal and vertical position from the sync
// edges. It checks the line length and frame length against the parameters and
// reports each active-area pixel with its coordinates and colour.
//
// Ports
//   dclk        in   pixel clock; all state changes on its rising edge
//   rst         in   asynchronous reset, active low
//   hsync       in   horizontal sync, active low
//   vsync       in   vertical sync, active low
//   red/green/blue in 3 bits each, incoming colour
//   px_x        out  10 bits, active-area column
//   px_y        out  10 bits, active-area row
//   px_rgb      out  9 bits, captured {red, green, blue}
//   px_valid    out  px_x/px_y/px_rgb describe an active pixel
//   frame_start out  one-cycle pulse with the pixel at (0,0)
//   locked      out  input timing matches the parameters
//   sync_err    out  one-cycle pulse on a timing violation
//
// Pipeline: pin sample -> input stage -> counters/FSM -> output registers,
// giving two dclk of latency from the pin sample to px_* and frame_start.
// ---------------------------------------------------------------------------
module vga_rx #(
    parameter int hpixels = 800,
    parameter int vlines  = 521,
    parameter int hbp     = 144,
    parameter int hfp     = 784,
    parameter int vbp     = 31,
    parameter int vfp     = 511
) (
    input  logic       dclk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [2:0] blue,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic [8:0] px_rgb,
    output logic       px_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [9:0] H_LAST   = 10'(hpixels - 1);
    localparam logic [9:0] V_LAST   = 10'(vlines - 1);
    localparam logic [9:0] H_BP     = 10'(hbp);
    localparam logic [9:0] H_FP     = 10'(hfp);
    localparam logic [9:0] V_BP     = 10'(vbp);
    localparam logic [9:0] V_FP     = 10'(vfp);
    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] CNT_NEAR = 10'd1022;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Input stage and edge-detect history
    logic       s_hs_q, s_hs_d;
    logic       s_vs_q, s_vs_d;
    logic [8:0] s_rgb_q, s_rgb_d;
    logic       p_hs_q, p_hs_d;
    logic       p_vs_q, p_vs_d;
    logic [1:0] prime_q, prime_d;
    logic [8:0] rgb_dly_q, rgb_dly_d;

    // Recovered position and lock state
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    state_t     state_q, state_d;
    logic       sync_err_q, sync_err_d;

    // Output registers
    logic [9:0] px_x_q, px_x_d;
    logic [9:0] px_y_q, px_y_d;
    logic [8:0] px_rgb_q, px_rgb_d;
    logic       px_valid_q, px_valid_d;
    logic       frame_start_q, frame_start_d;

    logic hfall;
    logic vfall;
    logic line_err;
    logic frame_err;
    logic timing_err;
    logic in_window;

    // prime_q[1] is set only once p_hs/p_vs hold a genuine pin sample, so the
    // reset value of the edge registers can never be mistaken for a falling
    // edge on the first sample after release.
    always_comb begin
        s_hs_d    = hsync;
        s_vs_d    = vsync;
        s_rgb_d   = {red, green, blue};
        p_hs_d    = s_hs_q;
        p_vs_d    = s_vs_q;
        prime_d   = {prime_q[0], 1'b1};
        rgb_dly_d = s_rgb_q;
        hfall     = prime_q[1] & p_hs_q & ~s_hs_q;
        vfall     = prime_q[1] & p_vs_q & ~s_vs_q;
    end

    // Position counters with saturation. A line that runs to 1023 is flagged
    // once, when the count first reaches the ceiling; the late hfall that
    // eventually ends such a line is flagged as a wrong length as well.
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        line_err  = 1'b0;
        frame_err = 1'b0;

        if (hfall) begin
            hcnt_d   = '0;
            line_err = (hcnt_q != H_LAST);
        end else begin
            if (hcnt_q != CNT_MAX) begin
                hcnt_d = hcnt_q + 10'd1;
            end
            line_err = (hcnt_q == CNT_NEAR);
        end

        // vfall wins over hfall: a coincident pair starts line 0 of a frame.
        if (vfall) begin
            vcnt_d    = '0;
            frame_err = (vcnt_q != V_LAST);
        end else if (hfall) begin
            if (vcnt_q != CNT_MAX) begin
                vcnt_d = vcnt_q + 10'd1;
            end
            frame_err = (vcnt_q == CNT_NEAR);
        end

        timing_err = line_err | frame_err;
    end

    // Lock FSM. Errors are checked before vfall so that a bad frame ending
    // on a vfall drops lock instead of relocking.
    always_comb begin
        state_d    = state_q;
        sync_err_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vfall) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (timing_err) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end else if (vfall) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (timing_err) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Output stage works on the registered counters and the colour delayed to
    // match them; coordinates and colour hold while outside the active area.
    always_comb begin
        in_window = (state_q == LOCKED)
                    && (hcnt_q >= H_BP) && (hcnt_q < H_FP)
                    && (vcnt_q >= V_BP) && (vcnt_q < V_FP);

        px_x_d        = px_x_q;
        px_y_d        = px_y_q;
        px_rgb_d      = px_rgb_q;
        px_valid_d    = in_window;
        frame_start_d = in_window && (hcnt_q == H_BP) && (vcnt_q == V_BP);

        if (in_window) begin
            px_x_d   = hcnt_q - H_BP;
            px_y_d   = vcnt_q - V_BP;
            px_rgb_d = rgb_dly_q;
        end
    end

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            s_hs_q        <= 1'b1;
            s_vs_q        <= 1'b1;
            s_rgb_q       <= '0;
            p_hs_q        <= 1'b1;
            p_vs_q        <= 1'b1;
            prime_q       <= '0;
            rgb_dly_q     <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            state_q       <= SEARCH;
            sync_err_q    <= 1'b0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            px_rgb_q      <= '0;
            px_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            s_hs_q        <= s_hs_d;
            s_vs_q        <= s_vs_d;
            s_rgb_q       <= s_rgb_d;
            p_hs_q        <= p_hs_d;
            p_vs_q        <= p_vs_d;
            prime_q       <= prime_d;
            rgb_dly_q     <= rgb_dly_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            state_q       <= state_d;
            sync_err_q    <= sync_err_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            px_rgb_q      <= px_rgb_d;
            px_valid_q    <= px_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign px_rgb      = px_rgb_q;
    assign px_valid    = px_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_rx -- self-checking bench for vga_rx
//
// Runs the receiver with a reduced 40x30 timing so whole frames are short.
// A behavioural model follows every pin sample: it measures line and frame
// lengths from the sync falls, tracks how many clean frames have been seen,
// and predicts the registered outputs. Directed scenarios add counts of
// sync_err pulses, valid pixels and frame starts.
// ---------------------------------------------------------------------------
module tb_vga_rx;

    localparam int HP   = 40;
    localparam int VL   = 30;
    localparam int HBP  = 8;
    localparam int HFP  = 36;
    localparam int VBP  = 3;
    localparam int VFP  = 27;
    localparam int HS_W = 4;
    localparam int VS_W = 2;
    localparam int ACTIVE = (HFP - HBP) * (VFP - VBP);

    logic       dclk;
    logic       rst;
    logic       hsync;
    logic       vsync;
    logic [2:0] red;
    logic [2:0] green;
    logic [2:0] blue;
    logic [9:0] px_x;
    logic [9:0] px_y;
    logic [8:0] px_rgb;
    logic       px_valid;
    logic       frame_start;
    logic       locked;
    logic       sync_err;

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
        logic [8:0] rgb;
        logic       fs;
        logic       lck;
        logic       serr;
    } exp_t;

    exp_t expq[$];

    int total;
    int bad;

    int obs_valid;
    int obs_fs;
    int obs_serr;
    int obs_unlocked;

    // Model state: samples since the last line start, lines since the last
    // frame start, and lock progress (0 hunting, 1 one clean frame pending,
    // 2 locked).
    int         m_hc;
    int         m_vc;
    int         m_level;
    bit         m_have_prev;
    logic       m_prev_hs;
    logic       m_prev_vs;
    logic [9:0] m_x;
    logic [9:0] m_y;
    logic [8:0] m_rgb;

    vga_rx #(
        .hpixels(HP),
        .vlines (VL),
        .hbp    (HBP),
        .hfp    (HFP),
        .vbp    (VBP),
        .vfp    (VFP)
    ) dut (
        .dclk       (dclk),
        .rst        (rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_rgb     (px_rgb),
        .px_valid   (px_valid),
        .frame_start(frame_start),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial begin
        dclk = 1'b0;
        forever #20 dclk = ~dclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_px_x"},   32'(px_x), 32'd0);
        chk({tag, "_px_y"},   32'(px_y), 32'd0);
        chk({tag, "_px_rgb"}, 32'(px_rgb), 32'd0);
        chk({tag, "_valid"},  32'(px_valid), 32'd0);
        chk({tag, "_fs"},     32'(frame_start), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_serr"},   32'(sync_err), 32'd0);
    endtask

    task automatic model_reset();
        m_hc        = 0;
        m_vc        = 0;
        m_level     = 0;
        m_have_prev = 1'b0;
        m_prev_hs   = 1'b1;
        m_prev_vs   = 1'b1;
        m_x         = '0;
        m_y         = '0;
        m_rgb       = '0;
    endtask

    // Predicts the outputs caused by one pin sample and queues them.
    task automatic model_step(input logic hs, input logic vs, input logic [8:0] rgb);
        exp_t e;
        bit   fall_h;
        bit   fall_v;
        bit   err;
        bit   serr;
        bit   valid;
        int   prev_hc;
        int   prev_vc;

        fall_h  = m_have_prev && m_prev_hs && !hs;
        fall_v  = m_have_prev && m_prev_vs && !vs;
        err     = 1'b0;
        prev_hc = m_hc;
        prev_vc = m_vc;

        // A line just ended is prev_hc+1 samples long.
        if (fall_h) begin
            if (prev_hc + 1 != HP) err = 1'b1;
            m_hc = 0;
        end else begin
            m_hc = (prev_hc < 1023) ? prev_hc + 1 : 1023;
            if (m_hc == 1023 && prev_hc != 1023) err = 1'b1;
        end

        if (fall_v) begin
            if (prev_vc + 1 != VL) err = 1'b1;
            m_vc = 0;
        end else if (fall_h) begin
            m_vc = (prev_vc < 1023) ? prev_vc + 1 : 1023;
            if (m_vc == 1023 && prev_vc != 1023) err = 1'b1;
        end

        serr = 1'b0;
        if (m_level == 0) begin
            if (fall_v) m_level = 1;
        end else if (err) begin
            m_level = 0;
            serr    = 1'b1;
        end else if (m_level == 1 && fall_v) begin
            m_level = 2;
        end

        valid = (m_level == 2) && (m_hc >= HBP) && (m_hc < HFP)
                && (m_vc >= VBP) && (m_vc < VFP);
        if (valid) begin
            m_x   = 10'(m_hc - HBP);
            m_y   = 10'(m_vc - VBP);
            m_rgb = rgb;
        end

        e.valid = valid;
        e.x     = m_x;
        e.y     = m_y;
        e.rgb   = m_rgb;
        e.fs    = valid && (m_hc == HBP) && (m_vc == VBP);
        e.lck   = (m_level == 2);
        e.serr  = serr;
        expq.push_back(e);

        m_prev_hs   = hs;
        m_prev_vs   = vs;
        m_have_prev = 1'b1;
    endtask

    // One dclk: check the outputs due now, then drive the next pin sample.
    // px_* lag the pin sample by two edges, locked/sync_err by one.
    task automatic tick(input logic hs, input logic vs, input logic [8:0] rgb);
        exp_t e;
        @(negedge dclk);
        if (expq.size() == 3) begin
            e = expq[0];
            chk("px_valid",    32'(px_valid), 32'(e.valid));
            chk("px_x",        32'(px_x), 32'(e.x));
            chk("px_y",        32'(px_y), 32'(e.y));
            chk("px_rgb",      32'(px_rgb), 32'(e.rgb));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            e = expq[1];
            chk("locked",      32'(locked), 32'(e.lck));
            chk("sync_err",    32'(sync_err), 32'(e.serr));
            void'(expq.pop_front());
        end
        obs_valid    += int'(px_valid);
        obs_fs       += int'(frame_start);
        obs_serr     += int'(sync_err);
        obs_unlocked += int'(!locked);
        hsync = hs;
        vsync = vs;
        {red, green, blue} = rgb;
        model_step(hs, vs, rgb);
    endtask

    // Called at a negedge; the pins already driven are the first sample taken.
    task automatic release_reset();
        rst = 1'b1;
        model_reset();
        expq.delete();
        model_step(hsync, vsync, {red, green, blue});
    endtask

    task automatic pulse_reset(input int n);
        @(negedge dclk);
        rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (n) begin
            @(negedge dclk);
            check_all_zero("rst_hold");
        end
        release_reset();
        obs_fs = 0;
    endtask

    task automatic clear_counts();
        obs_valid    = 0;
        obs_fs       = 0;
        obs_serr     = 0;
        obs_unlocked = 0;
    endtask

    // One frame of nominal-shape timing with optional faults injected.
    task automatic drive_frame(input int lines, input int short_line, input int stall_line,
                               input int reset_line, input bit rgb_hc);
        for (int vc = 0; vc < lines; vc++) begin
            int len;
            len = (vc == short_line) ? HP - 1 : HP;
            for (int hc = 0; hc < len; hc++) begin
                if (vc == stall_line && hc == 20) begin
                    repeat (1100) tick(1'b1, 1'b1, 9'($urandom));
                end
                if (vc == reset_line && hc == 20) begin
                    pulse_reset(3);
                end
                tick(hc >= HS_W, vc >= VS_W, rgb_hc ? 9'(hc) : 9'($urandom));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_counts();
        model_reset();
        hsync = 1'b1;
        vsync = 1'b1;
        red   = '0;
        green = '0;
        blue  = '0;
        rst   = 1'b1;
        #5 rst = 1'b0;

        // Reset state
        repeat (3) @(negedge dclk);
        check_all_zero("reset");
        release_reset();
        repeat (5) tick(1'b1, 1'b1, 9'($urandom));

        // Nominal timing: lock within two frames, then hold for ten
        drive_frame(VL, -1, -1, -1, 1'b0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("lock_within_2", 32'(locked), 32'd1);
        clear_counts();
        repeat (10) drive_frame(VL, -1, -1, -1, 1'b0);
        chk("nominal_unlocked_cycles", 32'(obs_unlocked), 32'd0);
        chk("nominal_sync_err", 32'(obs_serr), 32'd0);
        chk("nominal_valid_count", 32'(obs_valid), 32'(10 * ACTIVE));
        chk("nominal_frame_starts", 32'(obs_fs), 32'd10);

        // Colour equal to the horizontal position
        clear_counts();
        drive_frame(VL, -1, -1, -1, 1'b1);
        chk("colour_valid_count", 32'(obs_valid), 32'(ACTIVE));

        // One short line
        clear_counts();
        drive_frame(VL, 10, -1, -1, 1'b0);
        chk("short_sync_err", 32'(obs_serr), 32'd1);
        chk("short_unlocked", 32'(locked), 32'd0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("short_measuring", 32'(locked), 32'd0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("short_relocked", 32'(locked), 32'd1);
        chk("short_sync_err_total", 32'(obs_serr), 32'd1);

        // Frame one line short
        clear_counts();
        drive_frame(VL - 1, -1, -1, -1, 1'b0);
        chk("short_frame_pending", 32'(obs_serr), 32'd0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("short_frame_sync_err", 32'(obs_serr), 32'd1);
        chk("short_frame_unlocked", 32'(locked), 32'd0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("short_frame_relocked", 32'(locked), 32'd1);

        // hsync stuck high long enough to saturate the line counter
        clear_counts();
        drive_frame(VL, -1, 10, -1, 1'b0);
        chk("stall_sync_err", 32'(obs_serr), 32'd1);
        chk("stall_unlocked", 32'(locked), 32'd0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("stall_relocked", 32'(locked), 32'd1);
        chk("stall_sync_err_total", 32'(obs_serr), 32'd1);

        // Reset mid-line while locked
        clear_counts();
        drive_frame(VL, -1, -1, 10, 1'b0);
        chk("rst_rest_of_frame_fs", 32'(obs_fs), 32'd0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("rst_first_vfall_fs", 32'(obs_fs), 32'd0);
        chk("rst_first_vfall_locked", 32'(locked), 32'd0);
        drive_frame(VL, -1, -1, -1, 1'b0);
        chk("rst_second_vfall_fs", 32'(obs_fs), 32'd1);
        chk("rst_relocked", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
